// File: rtl/phase_meter_pkg.sv
// phase_meter_pkg: shared types and constants for phase_lag_meter.
// Holds the measurement FSM encoding and a signed saturation helper.
package phase_meter_pkg;

  localparam int CNT_W_DEF   = 12;
  localparam int TIMEOUT_DEF = 4095;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REF_LEAD = 2'd1,
    FB_LEAD  = 2'd2
  } state_e;

  function automatic logic signed [31:0] sat_s32(
    input logic signed [31:0] v,
    input int                 lim
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = lim;
    lo = -lim;
    if (v > hi) begin
      sat_s32 = hi;
    end else if (v < lo) begin
      sat_s32 = lo;
    end else begin
      sat_s32 = v;
    end
  endfunction

endpackage

// File: rtl/phase_lag_meter_sync_edge_det.sv
// sync_edge_det: N-flop synchronizer followed by a registered rise flag.
// Pin-to-flag latency is STAGES+1 clock edges.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              last_q, last_d;
  logic              rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    last_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/phase_lag_meter.sv
// phase_lag_meter: signed ref/fb edge lag in clk cycles over valid/ready.
// Optional `PHASE_AVG_EN averages 2**AVG_LOG2 results per output.
module phase_lag_meter
  import phase_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int AVG_LOG2    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               ref_in,
  input  logic               fb_in,
  output logic               err_valid,
  input  logic               err_ready,
  output logic signed [CNT_W:0] err,
  output logic               err_timeout,
  output logic               slip,
  output logic               overrun
);

  localparam int ERR_W = CNT_W + 1;
  localparam logic [CNT_W:0] TO_V = ERR_W'(TIMEOUT);

  logic ref_rise, fb_rise;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_ref (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ref_in),
    .rise (ref_rise)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_fb (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (fb_in),
    .rise (fb_rise)
  );

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     slip_q, slip_d;
  logic [CNT_W:0]           cnt_inc;
  logic signed [31:0]       mag32, raw32, sat32;
  logic                     res_v, res_to;
  logic signed [ERR_W-1:0]  res_val;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slip_d  = slip_q;
    res_v   = 1'b0;
    res_to  = 1'b0;
    raw32   = '0;
    cnt_inc = {1'b0, cnt_q} + 1'b1;
    mag32   = 32'(cnt_inc);
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (ref_rise && fb_rise) begin
            res_v = 1'b1;
          end else if (ref_rise) begin
            state_d = REF_LEAD;
          end else if (fb_rise) begin
            state_d = FB_LEAD;
          end
        end
        REF_LEAD, FB_LEAD: begin
          cnt_d = cnt_inc[CNT_W-1:0];
          // The lagging edge wins over timeout; a repeated lead edge restarts.
          if ((state_q == REF_LEAD) ? fb_rise : ref_rise) begin
            res_v   = 1'b1;
            state_d = IDLE;
          end else if (cnt_inc == TO_V) begin
            res_v   = 1'b1;
            res_to  = 1'b1;
            state_d = IDLE;
          end else if ((state_q == REF_LEAD) ? ref_rise : fb_rise) begin
            slip_d = 1'b1;
            cnt_d  = '0;
          end
          raw32 = (state_q == REF_LEAD) ? mag32 : -mag32;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    sat32   = sat_s32(raw32, TIMEOUT);
    res_val = sat32[ERR_W-1:0];
  end

  logic                    out_v, out_to;
  logic signed [ERR_W-1:0] out_val;

`ifdef PHASE_AVG_EN
  localparam int ACC_W = ERR_W + AVG_LOG2;

  logic signed [ACC_W-1:0] acc_q, acc_d, sum, shr;
  logic [AVG_LOG2-1:0]     win_q, win_d;
  logic                    tacc_q, tacc_d;

  always_comb begin
    acc_d   = acc_q;
    win_d   = win_q;
    tacc_d  = tacc_q;
    out_v   = 1'b0;
    out_to  = tacc_q | res_to;
    sum     = acc_q + {{AVG_LOG2{res_val[ERR_W-1]}}, res_val};
    shr     = sum >>> AVG_LOG2;
    out_val = shr[ERR_W-1:0];
    if (!en) begin
      acc_d  = '0;
      win_d  = '0;
      tacc_d = 1'b0;
    end else if (res_v) begin
      if (&win_q) begin
        out_v  = 1'b1;
        acc_d  = '0;
        win_d  = '0;
        tacc_d = 1'b0;
      end else begin
        acc_d  = sum;
        win_d  = win_q + AVG_LOG2'(1);
        tacc_d = out_to;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      win_q  <= '0;
      tacc_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      win_q  <= win_d;
      tacc_q <= tacc_d;
    end
  end
`else
  always_comb begin
    out_v   = res_v;
    out_to  = res_to;
    out_val = res_val;
  end
`endif

  logic                    valid_q, valid_d;
  logic                    to_q, to_d;
  logic                    ovr_q, ovr_d;
  logic signed [ERR_W-1:0] err_q, err_d;
  logic                    fire;

  always_comb begin
    valid_d = valid_q;
    to_d    = to_q;
    ovr_d   = ovr_q;
    err_d   = err_q;
    fire    = valid_q & err_ready;
    if (out_v) begin
      if (!valid_q || fire) begin
        valid_d = 1'b1;
        err_d   = out_val;
        to_d    = out_to;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      slip_q  <= 1'b0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      ovr_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slip_q  <= slip_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
    end
  end

  assign err_valid   = valid_q;
  assign err         = err_q;
  assign err_timeout = to_q;
  assign slip        = slip_q;
  assign overrun     = ovr_q;

endmodule
